// File: rtl/swg_loop_sequencer.sv
// Loop-nest step sequencer for the sliding-window generator.
// Staged register port, applied only on a frame boundary.
module swg_loop_sequencer #(
    parameter int LOOP_H_ITERATIONS    = 1,
    parameter int LOOP_W_ITERATIONS    = 1,
    parameter int LOOP_KH_ITERATIONS   = 0,
    parameter int LOOP_KW_ITERATIONS   = 2,
    parameter int LOOP_SIMD_ITERATIONS = 0,
    parameter int HEAD_INCR_SIMD       = 1,
    parameter int HEAD_INCR_KW         = 1,
    parameter int HEAD_INCR_KH         = 1,
    parameter int HEAD_INCR_W          = -1,
    parameter int HEAD_INCR_H          = -1,
    parameter int HEAD_INCR_LAST       = 0,
    parameter int TAIL_INCR_W          = 1,
    parameter int TAIL_INCR_H          = 1,
    parameter int TAIL_INCR_LAST       = 2,
    parameter int INCR_BITWIDTH        = 3,
    parameter int CNT_BITWIDTH         = 8
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic                     advance,
    output logic [INCR_BITWIDTH-1:0] addr_incr,
    output logic [INCR_BITWIDTH-1:0] tail_incr,
    output logic                     last,
    input  logic                     cfg_we,
    input  logic [3:0]               cfg_addr,
    input  logic [31:0]              cfg_data,
    input  logic                     cfg_commit,
    output logic                     cfg_pending
);

    localparam int CW = CNT_BITWIDTH;
    localparam int IW = INCR_BITWIDTH;

    localparam int L_H    = 0;
    localparam int L_W    = 1;
    localparam int L_KH   = 2;
    localparam int L_KW   = 3;
    localparam int L_SIMD = 4;

    localparam int I_SIMD = 0;
    localparam int I_KW   = 1;
    localparam int I_KH   = 2;
    localparam int I_W    = 3;
    localparam int I_H    = 4;
    localparam int I_LAST = 5;
    localparam int T_W    = 6;
    localparam int T_H    = 7;
    localparam int T_LAST = 8;

    typedef logic [4:0][CW-1:0] cnt_set_t;
    typedef logic [8:0][IW-1:0] inc_set_t;

    localparam cnt_set_t RST_CNT = {
        CW'(LOOP_SIMD_ITERATIONS),
        CW'(LOOP_KW_ITERATIONS),
        CW'(LOOP_KH_ITERATIONS),
        CW'(LOOP_W_ITERATIONS),
        CW'(LOOP_H_ITERATIONS)
    };

    localparam inc_set_t RST_INC = {
        IW'(TAIL_INCR_LAST),
        IW'(TAIL_INCR_H),
        IW'(TAIL_INCR_W),
        IW'(HEAD_INCR_LAST),
        IW'(HEAD_INCR_H),
        IW'(HEAD_INCR_W),
        IW'(HEAD_INCR_KH),
        IW'(HEAD_INCR_KW),
        IW'(HEAD_INCR_SIMD)
    };

    cnt_set_t stg_cnt;
    cnt_set_t stg_cnt_nxt;
    cnt_set_t act_cnt;
    cnt_set_t cnt;
    cnt_set_t step_cnt;
    inc_set_t stg_inc;
    inc_set_t stg_inc_nxt;
    inc_set_t act_inc;

    logic       frame_start;
    logic [4:0] cnt_nz;
    logic       carry;
    logic       apply;
    logic       cfg_data_unused;

    assign cfg_data_unused = ^cfg_data[31:CW];

    always_comb begin
        stg_cnt_nxt = stg_cnt;
        stg_inc_nxt = stg_inc;
        if (cfg_we) begin
            for (int i = 0; i < 5; i++) begin
                if (cfg_addr == 4'(i)) begin
                    stg_cnt_nxt[i] = cfg_data[CW-1:0];
                end
            end
            for (int i = 0; i < 9; i++) begin
                if (cfg_addr == 4'(i + 5)) begin
                    stg_inc_nxt[i] = cfg_data[IW-1:0];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            cnt_nz[i] = (cnt[i] != '0);
        end
    end

    assign last = ~|cnt_nz;

    always_comb begin
        addr_incr = act_inc[I_LAST];
        priority case (1'b1)
            cnt_nz[L_SIMD]: addr_incr = act_inc[I_SIMD];
            cnt_nz[L_KW]:   addr_incr = act_inc[I_KW];
            cnt_nz[L_KH]:   addr_incr = act_inc[I_KH];
            cnt_nz[L_W]:    addr_incr = act_inc[I_W];
            cnt_nz[L_H]:    addr_incr = act_inc[I_H];
            default:        addr_incr = act_inc[I_LAST];
        endcase
    end

    always_comb begin
        tail_incr = act_inc[T_LAST];
        priority case (1'b1)
            cnt_nz[L_W]: tail_incr = act_inc[T_W];
            cnt_nz[L_H]: tail_incr = act_inc[T_H];
            default:     tail_incr = act_inc[T_LAST];
        endcase
    end

    // Odometer: exhausted inner loops reload, first live one decrements.
    always_comb begin
        step_cnt = cnt;
        carry    = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            if (carry) begin
                if (cnt_nz[i]) begin
                    step_cnt[i] = cnt[i] - CW'(1);
                    carry       = 1'b0;
                end else begin
                    step_cnt[i] = act_cnt[i];
                end
            end
        end
    end

    // A commit landing on the frame-final advance takes effect there.
    always_comb begin
        apply = 1'b0;
        if (advance && last && (cfg_pending || cfg_commit)) begin
            apply = 1'b1;
        end
        if (cfg_pending && frame_start && !advance) begin
            apply = 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            stg_cnt     <= RST_CNT;
            stg_inc     <= RST_INC;
            act_cnt     <= RST_CNT;
            act_inc     <= RST_INC;
            cnt         <= RST_CNT;
            frame_start <= 1'b1;
            cfg_pending <= 1'b0;
        end else begin
            stg_cnt <= stg_cnt_nxt;
            stg_inc <= stg_inc_nxt;
            if (apply) begin
                act_cnt     <= stg_cnt_nxt;
                act_inc     <= stg_inc_nxt;
                cnt         <= stg_cnt_nxt;
                cfg_pending <= 1'b0;
            end else begin
                if (advance) begin
                    cnt <= step_cnt;
                end
                if (cfg_commit) begin
                    cfg_pending <= 1'b1;
                end
            end
            if (advance) begin
                frame_start <= last;
            end
        end
    end

endmodule

// File: tb/tb_swg_loop_sequencer.sv
// Bench for swg_loop_sequencer: directed frame scenarios plus
// randomized traffic against a nested-loop reference model.
module tb_swg_loop_sequencer;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        advance = 1'b0;
    logic [2:0]  addr_incr;
    logic [2:0]  tail_incr;
    logic        last;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [31:0] cfg_data = '0;
    logic        cfg_commit = 1'b0;
    logic        cfg_pending;

    int checks = 0;
    int errors = 0;

    always #5 ap_clk = ~ap_clk;

    swg_loop_sequencer dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .advance     (advance),
        .addr_incr   (addr_incr),
        .tail_incr   (tail_incr),
        .last        (last),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_commit  (cfg_commit),
        .cfg_pending (cfg_pending)
    );

    logic [2:0] def_a [12] = '{3'd1, 3'd1, 3'd7, 3'd1, 3'd1, 3'd7,
                               3'd1, 3'd1, 3'd7, 3'd1, 3'd1, 3'd0};
    logic [2:0] def_t [12] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1,
                               3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2};

    // Reference model: frame is enumerated as a plain nested loop.
    logic [7:0] m_stg_cnt [5];
    logic [7:0] m_act_cnt [5];
    logic [2:0] m_stg_inc [9];
    logic [2:0] m_act_inc [9];
    bit         m_pend;
    bit         m_fs;
    int         m_pos;
    logic [2:0] fq_a [$];
    logic [2:0] fq_t [$];

    function automatic void build_frame();
        logic [2:0] a;
        logic [2:0] t;
        fq_a.delete();
        fq_t.delete();
        for (int h = int'(m_act_cnt[0]); h >= 0; h--)
        for (int w = int'(m_act_cnt[1]); w >= 0; w--)
        for (int kh = int'(m_act_cnt[2]); kh >= 0; kh--)
        for (int kw = int'(m_act_cnt[3]); kw >= 0; kw--)
        for (int s = int'(m_act_cnt[4]); s >= 0; s--) begin
            if (s != 0)       a = m_act_inc[0];
            else if (kw != 0) a = m_act_inc[1];
            else if (kh != 0) a = m_act_inc[2];
            else if (w != 0)  a = m_act_inc[3];
            else if (h != 0)  a = m_act_inc[4];
            else              a = m_act_inc[5];
            if (w != 0)       t = m_act_inc[6];
            else if (h != 0)  t = m_act_inc[7];
            else              t = m_act_inc[8];
            fq_a.push_back(a);
            fq_t.push_back(t);
        end
    endfunction

    function automatic void model_reset();
        m_stg_cnt = '{8'd1, 8'd1, 8'd0, 8'd2, 8'd0};
        m_stg_inc = '{3'd1, 3'd1, 3'd1, 3'd7, 3'd7, 3'd0, 3'd1, 3'd1, 3'd2};
        m_act_cnt = m_stg_cnt;
        m_act_inc = m_stg_inc;
        m_pend = 1'b0;
        m_fs = 1'b1;
        m_pos = 0;
        build_frame();
    endfunction

    function automatic void model_edge();
        bit lastnow;
        bit apply;
        if (ap_rst) begin
            model_reset();
            return;
        end
        if (cfg_we) begin
            if (cfg_addr < 4'd5)
                m_stg_cnt[int'(cfg_addr)] = cfg_data[7:0];
            else if (cfg_addr < 4'd14)
                m_stg_inc[int'(cfg_addr) - 5] = cfg_data[2:0];
        end
        lastnow = (m_pos == fq_a.size() - 1);
        apply = ((m_pend || cfg_commit) && advance && lastnow) ||
                (m_pend && m_fs && !advance);
        if (advance) begin
            if (lastnow) begin
                m_pos = 0;
                m_fs = 1'b1;
            end else begin
                m_pos++;
                m_fs = 1'b0;
            end
        end
        if (apply) begin
            m_act_cnt = m_stg_cnt;
            m_act_inc = m_stg_inc;
            m_pend = 1'b0;
            m_pos = 0;
            build_frame();
        end else if (cfg_commit) begin
            m_pend = 1'b1;
        end
    endfunction

    task automatic drive(input bit adv, input bit we, input logic [3:0] a,
                         input logic [31:0] d, input bit cm, input bit rst);
        advance = adv;
        cfg_we = we;
        cfg_addr = a;
        cfg_data = d;
        cfg_commit = cm;
        ap_rst = rst;
    endtask

    task automatic tick();
        @(posedge ap_clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 1);
        tick();
        tick();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (addr_incr !== 3'd1) begin
            errors++;
            $display("FAIL reset_addr got %0d want 1", addr_incr);
        end
        checks++;
        if (tail_incr !== 3'd1) begin
            errors++;
            $display("FAIL reset_tail got %0d want 1", tail_incr);
        end
        checks++;
        if (last !== 1'b0) begin
            errors++;
            $display("FAIL reset_last got %0b want 0", last);
        end
        checks++;
        if (cfg_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_pending got %0b want 0", cfg_pending);
        end
    endtask

    task automatic test_default();
        do_reset();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 12; i++) begin
                drive(1, 0, 0, 0, 0, 0);
                checks++;
                if (addr_incr !== def_a[i] || tail_incr !== def_t[i] ||
                    last !== (i == 11)) begin
                    errors++;
                    $display("FAIL default step %0d got a=%0d t=%0d l=%0b want a=%0d t=%0d l=%0b",
                             i + 1, addr_incr, tail_incr, last,
                             def_a[i], def_t[i], i == 11);
                end
                tick();
            end
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_sparse();
        do_reset();
        for (int i = 0; i < 24; i++) begin
            drive(i[0], 0, 0, 0, 0, 0);
            checks++;
            if (addr_incr !== def_a[i / 2] || tail_incr !== def_t[i / 2] ||
                last !== (i / 2 == 11)) begin
                errors++;
                $display("FAIL sparse cycle %0d got a=%0d t=%0d l=%0b want a=%0d t=%0d",
                         i, addr_incr, tail_incr, last, def_a[i / 2], def_t[i / 2]);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (addr_incr !== 3'd1 || last !== 1'b0) begin
            errors++;
            $display("FAIL sparse_wrap got a=%0d l=%0b want a=1 l=0", addr_incr, last);
        end
    endtask

    task automatic test_commit_mid();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            tick();
        end
        drive(0, 1, 4'd3, 32'd0, 0, 0);
        tick();
        drive(0, 1, 4'd1, 32'd0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 0);
        tick();
        for (int i = 4; i < 12; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            checks++;
            if (cfg_pending !== 1'b1 || addr_incr !== def_a[i] ||
                last !== (i == 11)) begin
                errors++;
                $display("FAIL mid_old step %0d got a=%0d l=%0b p=%0b want a=%0d p=1",
                         i + 1, addr_incr, last, cfg_pending, def_a[i]);
            end
            tick();
        end
        drive(1, 0, 0, 0, 0, 0);
        checks++;
        if (cfg_pending !== 1'b0 || addr_incr !== 3'd7 || last !== 1'b0 ||
            tail_incr !== 3'd1) begin
            errors++;
            $display("FAIL mid_new1 got a=%0d t=%0d l=%0b p=%0b want a=7 t=1 l=0 p=0",
                     addr_incr, tail_incr, last, cfg_pending);
        end
        tick();
        checks++;
        if (addr_incr !== 3'd0 || last !== 1'b1 || tail_incr !== 3'd2) begin
            errors++;
            $display("FAIL mid_new2 got a=%0d t=%0d l=%0b want a=0 t=2 l=1",
                     addr_incr, tail_incr, last);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (addr_incr !== 3'd7 || last !== 1'b0) begin
            errors++;
            $display("FAIL mid_wrap got a=%0d l=%0b want a=7 l=0", addr_incr, last);
        end
    endtask

    task automatic test_commit_idle();
        logic [2:0] exp [6];
        exp = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd7};
        do_reset();
        drive(0, 1, 4'd4, 32'd1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (cfg_pending !== 1'b1) begin
            errors++;
            $display("FAIL idle_pending_rise got %0b want 1", cfg_pending);
        end
        tick();
        checks++;
        if (cfg_pending !== 1'b0) begin
            errors++;
            $display("FAIL idle_pending_fall got %0b want 0", cfg_pending);
        end
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            checks++;
            if (addr_incr !== exp[i] || last !== 1'b0) begin
                errors++;
                $display("FAIL idle_seq step %0d got a=%0d l=%0b want a=%0d l=0",
                         i + 1, addr_incr, last, exp[i]);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_degenerate();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 4'(i), 32'hFFFF_FF00, 0, 0);
            tick();
        end
        drive(0, 1, 4'd3, 32'd0, 1, 0);
        tick();
        drive(0, 1, 4'd4, 32'd0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (cfg_pending !== 1'b0) begin
            errors++;
            $display("FAIL degen_pending got %0b want 0", cfg_pending);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            checks++;
            if (last !== 1'b1 || addr_incr !== 3'd0 || tail_incr !== 3'd2) begin
                errors++;
                $display("FAIL degen step %0d got a=%0d t=%0d l=%0b want a=0 t=2 l=1",
                         i + 1, addr_incr, tail_incr, last);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            tick();
        end
        drive(0, 1, 4'd3, 32'd0, 1, 0);
        tick();
        checks++;
        if (cfg_pending !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pending_set got %0b want 1", cfg_pending);
        end
        drive(1, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (cfg_pending !== 1'b0 || addr_incr !== 3'd1 || tail_incr !== 3'd1 ||
            last !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_state got a=%0d t=%0d l=%0b p=%0b want a=1 t=1 l=0 p=0",
                     addr_incr, tail_incr, last, cfg_pending);
        end
        for (int i = 0; i < 14; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            checks++;
            if (addr_incr !== def_a[i % 12] || last !== (i == 11) ||
                cfg_pending !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_seq step %0d got a=%0d l=%0b p=%0b want a=%0d",
                         i + 1, addr_incr, last, cfg_pending, def_a[i % 12]);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        bit         adv;
        bit         we;
        bit         cm;
        bit         rst;
        logic [3:0] a;
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            adv = ($urandom_range(0, 99) < 70);
            we = ($urandom_range(0, 7) == 0);
            cm = ($urandom_range(0, 24) == 0);
            rst = ($urandom_range(0, 399) == 0);
            a = 4'($urandom_range(0, 15));
            if (a < 4'd5)
                d = ($urandom() & 32'hFFFF_FF00) | 32'($urandom_range(0, 2));
            else
                d = $urandom();
            drive(adv, we, a, d, cm, rst);
            checks++;
            if (addr_incr !== fq_a[m_pos] || tail_incr !== fq_t[m_pos] ||
                last !== (m_pos == fq_a.size() - 1) || cfg_pending !== m_pend) begin
                errors++;
                $display("FAIL random cyc %0d got a=%0d t=%0d l=%0b p=%0b want a=%0d t=%0d l=%0b p=%0b",
                         i, addr_incr, tail_incr, last, cfg_pending, fq_a[m_pos],
                         fq_t[m_pos], m_pos == fq_a.size() - 1, m_pend);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_default();
        test_sparse();
        test_commit_mid();
        test_commit_idle();
        test_degenerate();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
